// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported memory.
// One transaction in flight: arbitrate -> ISSUE (grant + memory access) -> RESP (response pulse).
module mem_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h8002_0000,
    parameter int unsigned MEM_BYTES    = 1048576,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_writing,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W:0]  LO_ADDR    = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0]  HI_ADDR    = (ADDR_W + 1)'(BASE_ADDR)
                                            + (ADDR_W + 1)'(MEM_BYTES)
                                            - (ADDR_W + 1)'(1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              owner_fetch_q, owner_fetch_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_writing_q, mem_writing_d;
    logic [1:0]        mem_size_q, mem_size_d;

    logic              sel_fetch;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_size;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W:0]   sel_span;
    logic              sel_size_bad;
    logic              sel_align_bad;
    logic              sel_range_bad;
    logic              sel_err;
    logic              arb_take;

    // Winner of the next arbitration and the fields it would latch.
    always_comb begin
        sel_fetch = if_req && (!d_req || (starve_q == STARVE_MAX));
        sel_addr  = sel_fetch ? if_addr : d_addr;
        sel_size  = sel_fetch ? SZ_WORD : d_size;
        sel_we    = !sel_fetch && d_we;
        sel_wdata = sel_fetch ? '0 : d_wdata;
    end

    // Access legality; the range test is done in 33 bits so a top-of-space access cannot wrap.
    always_comb begin
        sel_span = '0;
        case (sel_size)
            SZ_WORD: sel_span = (ADDR_W + 1)'(3);
            SZ_HALF: sel_span = (ADDR_W + 1)'(1);
            default: sel_span = '0;
        endcase
        sel_size_bad  = (sel_size == SZ_BAD);
        sel_align_bad = ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00))
                      || ((sel_size == SZ_HALF) && sel_addr[0]);
        sel_range_bad = ({1'b0, sel_addr} < LO_ADDR)
                      || (({1'b0, sel_addr} + sel_span) > HI_ADDR);
        sel_err       = sel_size_bad || sel_align_bad || sel_range_bad;
    end

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        owner_fetch_d = owner_fetch_q;
        we_d          = we_q;
        err_d         = err_q;
        if_gnt_d      = 1'b0;
        d_gnt_d       = 1'b0;
        if_rvalid_d   = 1'b0;
        d_rvalid_d    = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        mem_writing_d = 1'b0;
        mem_size_d    = SZ_WORD;
        arb_take      = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                state_d     = ST_RESP;
                rsp_rdata_d = (we_q || err_q) ? '0 : mem_rdata;
                rsp_err_d   = err_q;
                if (owner_fetch_q) begin
                    if_rvalid_d = 1'b1;
                end else begin
                    d_rvalid_d = 1'b1;
                end
            end
            default: begin
                // IDLE and RESP both arbitrate, giving one transaction per two cycles.
                if (if_req || d_req) begin
                    arb_take      = 1'b1;
                    state_d       = ST_ISSUE;
                    owner_fetch_d = sel_fetch;
                    we_d          = sel_we;
                    err_d         = sel_err;
                    if_gnt_d      = sel_fetch;
                    d_gnt_d       = !sel_fetch;
                    mem_addr_d    = sel_addr;
                    mem_wdata_d   = sel_wdata;
                    mem_size_d    = sel_size;
                    mem_writing_d = sel_we && !sel_err;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (!if_req) begin
            starve_d = '0;
        end else if (arb_take) begin
            if (sel_fetch) begin
                starve_d = '0;
            end else if (starve_q < STARVE_MAX) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            starve_q      <= '0;
            owner_fetch_q <= 1'b0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            if_gnt_q      <= 1'b0;
            d_gnt_q       <= 1'b0;
            if_rvalid_q   <= 1'b0;
            d_rvalid_q    <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_writing_q <= 1'b0;
            mem_size_q    <= SZ_WORD;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            owner_fetch_q <= owner_fetch_d;
            we_q          <= we_d;
            err_q         <= err_d;
            if_gnt_q      <= if_gnt_d;
            d_gnt_q       <= d_gnt_d;
            if_rvalid_q   <= if_rvalid_d;
            d_rvalid_q    <= d_rvalid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_writing_q <= mem_writing_d;
            mem_size_q    <= mem_size_d;
        end
    end

    assign if_gnt          = if_gnt_q;
    assign d_gnt           = d_gnt_q;
    assign if_rvalid       = if_rvalid_q;
    assign d_rvalid        = d_rvalid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_writing     = mem_writing_q;
    assign mem_access_size = mem_size_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, starvation/reset sequences, and randomized
// traffic checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam logic [31:0] BASE  = 32'h8002_0000;
    localparam int unsigned BYTES = 1048576;
    localparam int          LIMIT = 2;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_writing;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_rdata;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_writing(mem_writing),
        .mem_access_size(mem_access_size), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory seen by the DUT, and the model's own view of what memory should hold.
    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    bit          pend_wr;
    logic [31:0] pend_addr, pend_data;

    // Reference model state.
    bit          m_busy;
    int          m_starve;
    bit          t_fetch, t_we, t_err;
    logic [31:0] t_addr, t_wdata;

    logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_err, e_mwr;
    logic [31:0] e_rdata, e_maddr, e_mwdata;
    logic [1:0]  e_msize;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] phys_read(input logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : pat(a);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    function automatic bit access_err(input bit fetch, input logic [1:0] sz, input logic [31:0] a);
        longint unsigned n, lo, hi, la;
        logic [1:0] s;
        s = fetch ? 2'b00 : sz;
        if (s == 2'b11) return 1'b1;
        n  = (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : 1;
        la = longint'(a);
        if ((la % n) != 0) return 1'b1;
        lo = longint'(BASE);
        hi = lo + longint'(BYTES) - 1;
        return (la < lo) || (la + n - 1 > hi);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_all();
        chk("if_gnt",      32'(if_gnt),          32'(e_if_gnt));
        chk("d_gnt",       32'(d_gnt),           32'(e_d_gnt));
        chk("if_rvalid",   32'(if_rvalid),       32'(e_if_rv));
        chk("d_rvalid",    32'(d_rvalid),        32'(e_d_rv));
        chk("rsp_rdata",   rsp_rdata,            e_rdata);
        chk("rsp_err",     32'(rsp_err),         32'(e_err));
        chk("mem_addr",    mem_addr,             e_maddr);
        chk("mem_wdata",   mem_wdata,            e_mwdata);
        chk("mem_writing", 32'(mem_writing),     32'(e_mwr));
        chk("mem_size",    32'(mem_access_size), 32'(e_msize));
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_starve = 0;
        e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_err = 0; e_mwr = 0;
        e_rdata = '0; e_maddr = '0; e_mwdata = '0; e_msize = '0;
    endtask

    // One rising edge of the reference model, using the inputs the DUT sees at that edge.
    task automatic model_step();
        bit took, fw;
        took = 1'b0; fw = 1'b0;
        e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0;
        e_mwr = 0; e_maddr = '0; e_mwdata = '0; e_msize = '0;
        if (m_busy) begin
            if (t_fetch) e_if_rv = 1; else e_d_rv = 1;
            e_err   = t_err;
            e_rdata = (t_we || t_err) ? 32'h0 : ref_read(t_addr);
            if (t_we && !t_err) ref_mem[t_addr] = t_wdata;
            m_busy = 1'b0;
        end else if (if_req || d_req) begin
            took    = 1'b1;
            fw      = if_req && (!d_req || m_starve == LIMIT);
            t_fetch = fw;
            t_addr  = fw ? if_addr : d_addr;
            t_we    = !fw && d_we;
            t_wdata = d_wdata;
            t_err   = access_err(fw, d_size, t_addr);
            if (fw) e_if_gnt = 1; else e_d_gnt = 1;
            e_maddr  = t_addr;
            e_mwdata = fw ? 32'h0 : d_wdata;
            e_msize  = fw ? 2'b00 : d_size;
            e_mwr    = t_we && !t_err;
            m_busy   = 1'b1;
        end
        if (!if_req) m_starve = 0;
        else if (took) m_starve = fw ? 0 : ((m_starve < LIMIT) ? m_starve + 1 : LIMIT);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (pend_wr) begin
            phys_mem[pend_addr] = pend_data;
            pend_wr = 1'b0;
        end
        model_step();
        #1;
        chk_all();
        if (mem_writing) begin
            pend_wr = 1'b1; pend_addr = mem_addr; pend_data = mem_wdata;
        end
        mem_rdata = phys_read(mem_addr);
    endtask

    task automatic run_vec(input vec_t v);
        int wr_cnt;
        bit got;
        d_req = 1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
        wr_cnt = 0; got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            cycle();
            if (mem_writing) wr_cnt++;
            if (d_gnt) got = 1;
        end
        chk("vec_gnt", 32'(got), 32'd1);
        d_req = 0; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            cycle();
            if (mem_writing) wr_cnt++;
            if (d_rvalid) got = 1;
        end
        chk("vec_rvalid", 32'(got), 32'd1);
        chk("vec_err", 32'(rsp_err), 32'(v.exp_err));
        chk("vec_rdata", rsp_rdata, v.exp_rdata);
        chk("vec_writes", 32'(wr_cnt), 32'(v.we && !v.exp_err));
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 8)
            0: return 32'h7FFF_FFFC;
            1: return BASE + 32'(BYTES) - 32'd4;
            2: return $urandom;
            default: return BASE + 32'(($urandom % 64) * 4)
                          + (($urandom % 8 == 0) ? 32'($urandom % 4) : 32'd0);
        endcase
    endfunction

    initial begin
        int gk[$];
        int gc[$];
        int exp_kind [6];
        bit got;

        tbl[0]  = '{1'b1, 2'b00, 32'h8002_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'b00, 32'h8002_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 2'b00, 32'h8002_0002, 32'h0,         1'b1, 32'h0};
        tbl[3]  = '{1'b1, 2'b00, 32'h7FFF_FFFC, 32'h1234_5678, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 2'b11, 32'h8002_0020, 32'h0,         1'b1, 32'h0};
        tbl[5]  = '{1'b0, 2'b00, 32'h8011_FFFC, 32'h0,         1'b0, pat(32'h8011_FFFC)};
        tbl[6]  = '{1'b0, 2'b01, 32'h8011_FFFE, 32'h0,         1'b0, pat(32'h8011_FFFE)};
        tbl[7]  = '{1'b0, 2'b00, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
        tbl[8]  = '{1'b1, 2'b10, 32'h8011_FFFF, 32'h0000_00AB, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 2'b10, 32'h8011_FFFF, 32'h0,         1'b0, 32'h0000_00AB};
        tbl[10] = '{1'b0, 2'b01, 32'h8011_FFFF, 32'h0,         1'b1, 32'h0};
        tbl[11] = '{1'b0, 2'b00, 32'h8012_0000, 32'h0,         1'b1, 32'h0};
        tbl[12] = '{1'b0, 2'b00, 32'h8001_FFFC, 32'h0,         1'b1, 32'h0};
        tbl[13] = '{1'b1, 2'b01, 32'h8002_0000, 32'h0000_CAFE, 1'b0, 32'h0};
        exp_kind = '{0, 0, 1, 0, 0, 1};

        rst_n = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0; pend_wr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        rst_n = 1;
        cycle();

        foreach (tbl[i]) run_vec(tbl[i]);

        // Both ports held: fetch must win every (LIMIT+1)th grant, grants two cycles apart.
        if_req = 1; if_addr = 32'h8002_0100;
        d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 32'h8002_0104; d_wdata = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (if_gnt) begin gk.push_back(1); gc.push_back(c); end
            if (d_gnt)  begin gk.push_back(0); gc.push_back(c); end
        end
        if_req = 0; d_req = 0;
        chk("grant_count", 32'(gk.size()), 32'd6);
        for (int i = 0; i < 6 && i < gk.size(); i++) begin
            chk("grant_order", 32'(gk[i]), 32'(exp_kind[i]));
            if (i > 0) chk("grant_gap", 32'(gc[i] - gc[i-1]), 32'd2);
        end
        repeat (2) cycle();

        // Reset in the middle of a store's ISSUE cycle.
        d_req = 1; d_we = 1; d_size = 2'b00; d_addr = 32'h8002_0040; d_wdata = 32'h1111_2222;
        cycle();
        chk("rst_store_issue", 32'(mem_writing), 32'd1);
        d_req = 0; d_we = 0;
        #2;
        rst_n = 0;
        #1;
        pend_wr = 0;
        model_reset();
        chk("rst_mem_writing", 32'(mem_writing), 32'd0);
        chk_all();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_rvalid", 32'(d_rvalid), 32'd0);
            chk_all();
        end
        rst_n = 1;
        if_req = 1; if_addr = 32'h8002_0040;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            cycle();
            if (if_gnt) if_req = 0;
            if (if_rvalid) got = 1;
        end
        chk("post_rst_fetch", 32'(got), 32'd1);
        chk("post_rst_rdata", rsp_rdata, pat(32'h8002_0040));
        chk("post_rst_err", 32'(rsp_err), 32'd0);

        // Randomized traffic from two well-behaved masters, with occasional request withdrawal.
        for (int n = 0; n < 3000; n++) begin
            cycle();
            if (if_gnt) if_req = 0;
            if (d_gnt) d_req = 0;
            if (!if_req && ($urandom % 3 == 0)) begin
                if_req = 1; if_addr = rand_addr();
            end else if (if_req && !if_gnt && ($urandom % 60 == 0)) begin
                if_req = 0;
            end
            if (!d_req && ($urandom % 2 == 0)) begin
                d_req = 1; d_we = 1'($urandom); d_addr = rand_addr();
                d_size = ($urandom % 10 == 0) ? 2'b11 : 2'($urandom % 3);
                d_wdata = $urandom;
            end else if (d_req && !d_gnt && ($urandom % 60 == 0)) begin
                d_req = 0;
            end
        end
        if_req = 0; d_req = 0;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
